// File: rtl/sqm_op_sequencer.sv
// Round-robin front end for a shared square-mod / shuffle unit followed by a
// bit-serial longest-ones-run scan; exactly one operation is in flight at a time.
module sqm_op_sequencer #(
  parameter int RESET_PRIO = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req0_valid,
  input  logic       req0_op,
  input  logic [7:0] req0_a,
  input  logic [3:0] req0_b,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_op,
  input  logic [7:0] req1_a,
  input  logic [3:0] req1_b,
  output logic       req1_ready,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_y,
  output logic [3:0] rsp_z,
  output logic       rsp_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SQUARE,
    S_MOD,
    S_SHUF,
    S_SCAN,
    S_DONE
  } state_t;

  state_t     state_q;
  logic       rr_q;       // 1 favours requester 1 when both are valid
  logic       id_q;
  logic [7:0] a_q;
  logic [3:0] b_q;
  logic [7:0] c_q;
  logic [7:0] rem_q;
  logic [7:0] y_q;
  logic [2:0] cnt_q;
  logic [3:0] cur_q;
  logic [3:0] max_q;
  logic       err_q;
  logic       rsp_valid_q;
  logic       rsp_id_q;
  logic [7:0] rsp_y_q;
  logic [3:0] rsp_z_q;
  logic       rsp_err_q;

  logic       idle;
  logic       grant0;
  logic       grant1;
  logic [7:0] sq_d;
  logic [8:0] rem_shift_d;
  logic       rem_ge_d;
  logic [7:0] rem_d;
  logic [7:0] shuf_d;
  logic [3:0] cur_d;
  logic [3:0] max_d;

  assign idle       = (state_q == S_IDLE);
  assign grant0     = req0_valid & (~req1_valid | ~rr_q);
  assign grant1     = req1_valid & (~req0_valid | rr_q);
  assign req0_ready = idle & grant0;
  assign req1_ready = idle & grant1;

  assign sq_d = {4'd0, b_q} * {4'd0, b_q};

  // One restoring step: shift the next dividend bit in, subtract when it fits.
  assign rem_shift_d = {rem_q, c_q[7]};
  assign rem_ge_d    = (rem_shift_d >= {1'b0, a_q});
  assign rem_d       = rem_ge_d ? 8'(rem_shift_d - {1'b0, a_q}) : rem_shift_d[7:0];

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_shuf
      assign shuf_d[gi] = b_q[{a_q[(gi + 1) % 8], a_q[gi]}];
    end
  endgenerate

  assign cur_d = y_q[cnt_q] ? (cur_q + 4'd1) : 4'd0;
  assign max_d = (cur_d > max_q) ? cur_d : max_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      rr_q        <= (RESET_PRIO != 0);
      id_q        <= 1'b0;
      a_q         <= 8'd0;
      b_q         <= 4'd0;
      c_q         <= 8'd0;
      rem_q       <= 8'd0;
      y_q         <= 8'd0;
      cnt_q       <= 3'd0;
      cur_q       <= 4'd0;
      max_q       <= 4'd0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_y_q     <= 8'd0;
      rsp_z_q     <= 4'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant0 | grant1) begin
            id_q    <= grant1;
            a_q     <= grant1 ? req1_a : req0_a;
            b_q     <= grant1 ? req1_b : req0_b;
            rr_q    <= ~grant1;
            err_q   <= 1'b0;
            state_q <= (grant1 ? req1_op : req0_op) ? S_SQUARE : S_SHUF;
          end
        end
        S_SQUARE: begin
          cnt_q <= 3'd0;
          cur_q <= 4'd0;
          max_q <= 4'd0;
          if (a_q == 8'd0) begin
            y_q     <= sq_d;
            err_q   <= 1'b1;
            state_q <= S_SCAN;
          end else begin
            c_q     <= sq_d;
            rem_q   <= 8'd0;
            state_q <= S_MOD;
          end
        end
        S_MOD: begin
          rem_q <= rem_d;
          c_q   <= {c_q[6:0], 1'b0};
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            y_q     <= rem_d;
            cur_q   <= 4'd0;
            max_q   <= 4'd0;
            state_q <= S_SCAN;
          end
        end
        S_SHUF: begin
          y_q     <= shuf_d;
          cnt_q   <= 3'd0;
          cur_q   <= 4'd0;
          max_q   <= 4'd0;
          state_q <= S_SCAN;
        end
        S_SCAN: begin
          cur_q <= cur_d;
          max_q <= max_d;
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= id_q;
            rsp_y_q     <= y_q;
            rsp_z_q     <= max_d;
            rsp_err_q   <= err_q;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_z     = rsp_z_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_sqm_op_sequencer.sv
// Scoreboard bench for sqm_op_sequencer: accepted operations push a reference
// result; a negedge monitor checks arbitration, latency and response fields.
module tb_sqm_op_sequencer;

  localparam int TB_PRIO = 0;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req0_valid, req0_op, req0_ready;
  logic [7:0] req0_a;
  logic [3:0] req0_b;
  logic       req1_valid, req1_op, req1_ready;
  logic [7:0] req1_a;
  logic [3:0] req1_b;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [7:0] rsp_y;
  logic [3:0] rsp_z;

  sqm_op_sequencer #(.RESET_PRIO(TB_PRIO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_y(rsp_y), .rsp_z(rsp_z), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         id;
    logic [7:0] y;
    logic [3:0] z;
    bit         err;
    int         lat;
  } exp_t;

  exp_t exp_q[$];
  int   grant_log[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   m_busy = 0, m_done = 0, m_ptr = 1'(TB_PRIO);
  int   m_acc = 0;
  bit   e0, e1;
  int   done_cnt;
  int   sn;
  logic [7:0] cap_y;
  logic [3:0] cap_z;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input bit ok, input int act, input int expv);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference result straight from the operation definitions.
  function automatic exp_t model(input bit op, input logic [7:0] a, input logic [3:0] b);
    exp_t e;
    int c, cur, best, idx;
    c = int'(b) * int'(b);
    e.id = 0;
    e.err = 0;
    e.y = 8'd0;
    if (op) begin
      if (a == 8'd0) begin
        e.y = 8'(c);
        e.err = 1;
        e.lat = 10;
      end else begin
        e.y = 8'(c % int'(a));
        e.lat = 18;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        idx = 2 * int'(a[(i + 1) % 8]) + int'(a[i]);
        e.y[i] = b[idx];
      end
      e.lat = 10;
    end
    cur = 0;
    best = 0;
    for (int i = 0; i < 8; i++) begin
      cur = e.y[i] ? cur + 1 : 0;
      if (cur > best) best = cur;
    end
    e.z = 4'(best);
    return e;
  endfunction

  // Monitor: arbitration, response timing and response contents.
  always @(negedge clk) begin
    if (!reset_n) begin
      m_busy = 0;
      m_done = 0;
      m_ptr  = 1'(TB_PRIO);
    end else begin
      e0 = !m_busy && req0_valid && (!req1_valid || !m_ptr);
      e1 = !m_busy && req1_valid && (!req0_valid || m_ptr);
      chk("req0_ready", req0_ready === e0, int'(req0_ready), int'(e0));
      chk("req1_ready", req1_ready === e1, int'(req1_ready), int'(e1));
      if (m_busy && !m_done && exp_q.size() > 0 && (cyc - m_acc) == exp_q[0].lat)
        m_done = 1;
      chk("rsp_valid", rsp_valid === m_done, int'(rsp_valid), int'(m_done));
      if (m_done && exp_q.size() > 0) begin
        chk("rsp_id", rsp_id === exp_q[0].id, int'(rsp_id), int'(exp_q[0].id));
        chk("rsp_y", rsp_y === exp_q[0].y, int'(rsp_y), int'(exp_q[0].y));
        chk("rsp_z", rsp_z === exp_q[0].z, int'(rsp_z), int'(exp_q[0].z));
        chk("rsp_err", rsp_err === exp_q[0].err, int'(rsp_err), int'(exp_q[0].err));
      end
      if (m_done && rsp_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        m_done = 0;
        m_busy = 0;
      end else if (!m_busy && ((req0_valid && req0_ready) || (req1_valid && req1_ready))) begin
        m_busy = 1;
        m_acc  = cyc;
        m_ptr  = !(req1_valid && req1_ready);
      end
    end
  end

  // Present one operation; returns at posedge+1 after the accepting edge.
  task automatic issue(input bit id, input bit op, input logic [7:0] a,
                       input logic [3:0] b, input bit keep);
    exp_t e;
    bit acc;
    int n;
    e = model(op, a, b);
    e.id = id;
    if (id == 0) begin
      req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
    end else begin
      req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
    end
    acc = 0;
    n = 0;
    while (!acc && n < 400) begin
      @(negedge clk);
      acc = (id == 0) ? req0_ready : req1_ready;
      n++;
    end
    if (acc) begin
      exp_q.push_back(e);
      grant_log.push_back(int'(id));
    end else begin
      chk("accept_timeout", 1'b0, n, 400);
    end
    @(posedge clk);
    #1;
    if (!keep || !acc) begin
      if (id == 0) req0_valid = 1'b0;
      else req1_valid = 1'b0;
    end
    $display("issue id=%0d op=%0d a=0x%02h b=0x%01h exp_y=0x%02h exp_z=%0d exp_err=%0d accepted=%0d",
             id, op, a, b, e.y, e.z, e.err, acc);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", n < 500, n, 500);
    @(posedge clk);
    #1;
  endtask

  task automatic rand_issue(input bit id);
    bit op;
    logic [7:0] a;
    logic [3:0] b;
    int g;
    op = 1'($urandom_range(0, 1));
    a  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
    b  = 4'($urandom);
    issue(id, op, a, b, 0);
    g = $urandom_range(0, 3);
    if (g > 0) begin
      repeat (g) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("reset_rsp_valid", rsp_valid === 1'b0, int'(rsp_valid), 0);
    chk("reset_rsp_y", rsp_y === 8'd0, int'(rsp_y), 0);
    chk("reset_rsp_z", rsp_z === 4'd0, int'(rsp_z), 0);
    chk("reset_rsp_err", rsp_err === 1'b0, int'(rsp_err), 0);
    chk("reset_rsp_id", rsp_id === 1'b0, int'(rsp_id), 0);

    // Both requesters continuously valid from reset: grants must alternate.
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    grant_log.delete();
    fork
      begin issue(0, 1, 8'd200, 4'd11, 1); issue(0, 0, 8'hA5, 4'd6, 0); end
      begin issue(1, 0, 8'h3C, 4'd9, 1);   issue(1, 1, 8'd3, 4'd15, 0); end
    join
    wait_idle();
    chk("grant_count", grant_log.size() == 4, grant_log.size(), 4);
    for (int i = 0; i < grant_log.size() && i < 4; i++)
      chk("grant_order", grant_log[i] == (i % 2), grant_log[i], i % 2);

    // Directed operations.
    issue(0, 1, 8'd7, 4'd9, 0);      wait_idle();
    issue(1, 0, 8'h00, 4'b0001, 0);  wait_idle();
    issue(0, 1, 8'd0, 4'd5, 0);      wait_idle();

    // Back-pressure in DONE with a competing request pending.
    rsp_ready = 1'b0;
    fork
      begin
        issue(1, 1, 8'd13, 4'd14, 0);
        sn = 0;
        while (!rsp_valid && sn < 100) begin
          @(negedge clk);
          sn++;
        end
        chk("stall_wait", rsp_valid === 1'b1, int'(rsp_valid), 1);
        cap_y = rsp_y;
        cap_z = rsp_z;
        repeat (5) begin
          @(negedge clk);
          chk("stall_valid", rsp_valid === 1'b1, int'(rsp_valid), 1);
          chk("stall_y", rsp_y === cap_y, int'(rsp_y), int'(cap_y));
          chk("stall_z", rsp_z === cap_z, int'(rsp_z), int'(cap_z));
          chk("stall_req0_ready", req0_ready === 1'b0, int'(req0_ready), 0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("valid_drop", rsp_valid === 1'b0, int'(rsp_valid), 0);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        issue(0, 0, 8'h5A, 4'b1010, 0);
      end
    join
    wait_idle();

    // Randomized traffic with random consumer back-pressure.
    done_cnt = 0;
    fork
      begin for (int k = 0; k < 20; k++) rand_issue(0); done_cnt++; end
      begin for (int k = 0; k < 20; k++) rand_issue(1); done_cnt++; end
      begin
        while (done_cnt < 2) begin
          @(posedge clk);
          #1;
          if (done_cnt < 2) rsp_ready = 1'($urandom_range(0, 1));
        end
        rsp_ready = 1'b1;
      end
    join
    rsp_ready = 1'b1;
    wait_idle();

    // Reset during MOD drops the operation without a response.
    issue(0, 1, 8'd16, 4'd15, 0);
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("abort_rsp_valid", rsp_valid === 1'b0, int'(rsp_valid), 0);
    chk("abort_rsp_y", rsp_y === 8'd0, int'(rsp_y), 0);
    chk("abort_rsp_z", rsp_z === 4'd0, int'(rsp_z), 0);
    chk("abort_rsp_err", rsp_err === 1'b0, int'(rsp_err), 0);
    chk("abort_rsp_id", rsp_id === 1'b0, int'(rsp_id), 0);
    @(posedge clk);
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    issue(0, 1, 8'd16, 4'd15, 0);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got cycle %0d expected completion", cyc);
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
